ctrl_pipeline: RTL



---
 rtl/ctrl_pkg.sv | 21 ++
 rtl/hazard_unit.sv | 26 ++
 rtl/ctrl_pipeline.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared control-bundle types for the ctrl pipeline.
// Holds the decoder bundle layout, bubble constant and width defaults.
package ctrl_pkg;

  localparam int CTRL_REG_W  = 5;
  localparam int CTRL_ALUC_W = 4;

  typedef struct packed {
    logic                   reg_dest;
    logic                   branch;
    logic                   mem_read;
    logic                   mem_to_reg;
    logic                   mem_write;
    logic                   alu_src;
    logic                   reg_write;
    logic [CTRL_ALUC_W-1:0] alu_ctrl;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: combinational load-use comparator for ctrl_pipeline.
// Built only when CTRL_PIPE_HAZARD_EN is defined.
`ifdef CTRL_PIPE_HAZARD_EN
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             flush,
  output logic             stall
);

  // A load in EX feeding an ID source; r0 never counts, flush wins.
  always_comb begin
    stall = id_valid & ex_valid & ex_mem_read
          & (ex_dest != '0)
          & ((ex_dest == id_rs) | (ex_dest == id_rt))
          & ~flush;
  end

endmodule
`endif

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: carries decoder controls through EX, MEM and WB.
// Load-use stall logic is present only with CTRL_PIPE_HAZARD_EN.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_W  = CTRL_REG_W,
  parameter int ALUC_W = CTRL_ALUC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_reg_dest,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic [ALUC_W-1:0] id_alu_ctrl,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_alu_src,
  output logic              ex_reg_dest,
  output logic [ALUC_W-1:0] ex_alu_ctrl,
  output logic [REG_W-1:0]  ex_dest,
  output logic              mem_valid,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_branch,
  output logic [REG_W-1:0]  mem_dest,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_W-1:0]  wb_dest
);

  ctrl_bundle_t     id_ctrl;

  logic             ex_valid_q, ex_valid_d;
  ctrl_bundle_t     ex_ctrl_q, ex_ctrl_d;
  logic [REG_W-1:0] ex_dest_q, ex_dest_d;

  logic             mem_valid_q, mem_valid_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             mem_branch_q, mem_branch_d;
  logic             mem_m2r_q, mem_m2r_d;
  logic             mem_rw_q, mem_rw_d;
  logic [REG_W-1:0] mem_dest_q, mem_dest_d;

  logic             wb_valid_q, wb_valid_d;
  logic             wb_rw_q, wb_rw_d;
  logic             wb_m2r_q, wb_m2r_d;
  logic [REG_W-1:0] wb_dest_q, wb_dest_d;

  // Pack the decoder outputs into one bundle.
  always_comb begin
    id_ctrl            = CTRL_BUBBLE;
    id_ctrl.reg_dest   = id_reg_dest;
    id_ctrl.branch     = id_branch;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.alu_ctrl   = id_alu_ctrl;
  end

`ifdef CTRL_PIPE_HAZARD_EN
  hazard_unit #(
    .REG_W (REG_W)
  ) u_hazard (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_dest     (ex_dest_q),
    .flush       (flush),
    .stall       (stall)
  );
`else
  logic unused_srcs;
  assign unused_srcs = ^{id_rs, id_rt};
  assign stall = 1'b0;
`endif

  // ID->EX: bubble on invalid ID, stall or flush.
  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = CTRL_BUBBLE;
    ex_dest_d  = '0;
    if (id_valid && !stall && !flush) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_dest_d  = id_reg_dest ? id_rd : id_rt;
    end
  end

  // EX->MEM: flush kills the instruction leaving EX.
  always_comb begin
    mem_valid_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_branch_d = 1'b0;
    mem_m2r_d    = 1'b0;
    mem_rw_d     = 1'b0;
    mem_dest_d   = '0;
    if (!flush) begin
      mem_valid_d  = ex_valid_q;
      mem_read_d   = ex_ctrl_q.mem_read;
      mem_write_d  = ex_ctrl_q.mem_write;
      mem_branch_d = ex_ctrl_q.branch;
      mem_m2r_d    = ex_ctrl_q.mem_to_reg;
      mem_rw_d     = ex_ctrl_q.reg_write;
      mem_dest_d   = ex_dest_q;
    end
  end

  // MEM->WB: always advances so a taken branch retires.
  always_comb begin
    wb_valid_d = mem_valid_q;
    wb_rw_d    = mem_rw_q;
    wb_m2r_d   = mem_m2r_q;
    wb_dest_d  = mem_dest_q;
  end

  // Stage registers; reset loads bubbles everywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= CTRL_BUBBLE;
      ex_dest_q    <= '0;
      mem_valid_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_branch_q <= 1'b0;
      mem_m2r_q    <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_dest_q   <= '0;
      wb_valid_q   <= 1'b0;
      wb_rw_q      <= 1'b0;
      wb_m2r_q     <= 1'b0;
      wb_dest_q    <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_dest_q    <= ex_dest_d;
      mem_valid_q  <= mem_valid_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_branch_q <= mem_branch_d;
      mem_m2r_q    <= mem_m2r_d;
      mem_rw_q     <= mem_rw_d;
      mem_dest_q   <= mem_dest_d;
      wb_valid_q   <= wb_valid_d;
      wb_rw_q      <= wb_rw_d;
      wb_m2r_q     <= wb_m2r_d;
      wb_dest_q    <= wb_dest_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_reg_dest   = ex_ctrl_q.reg_dest;
  assign ex_alu_ctrl   = ex_ctrl_q.alu_ctrl;
  assign ex_dest       = ex_dest_q;
  assign mem_valid     = mem_valid_q;
  assign mem_mem_read  = mem_read_q;
  assign mem_mem_write = mem_write_q;
  assign mem_branch    = mem_branch_q;
  assign mem_dest      = mem_dest_q;
  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_rw_q;
  assign wb_mem_to_reg = wb_m2r_q;
  assign wb_dest       = wb_dest_q;

endmodule
